// File: rtl/param_shift_buffer.sv
// WIDTH-bit, DEPTH-stage registered delay line with per-stage valid bits, run-time tap select,
// stall, flush and occupancy count. Define BUFFER_CHANGE_DETECT_EN to build the out_changed detector.
module param_shift_buffer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int SELW  = $clog2(DEPTH),
   parameter int CNTW  = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SELW-1:0]  delay_sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [CNTW-1:0]  occupancy,
   output logic             out_changed
);

   logic [WIDTH-1:0] stage_data [DEPTH];
   logic [DEPTH-1:0] stage_vld;
   logic [CNTW-1:0]  occ;
   logic [SELW-1:0]  tap;

   // Flush only drops valid bits; stale data stays in place but is never presented as valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_data[i] <= '0;
         end
         stage_vld <= '0;
         occ       <= '0;
      end else if (flush) begin
         stage_vld <= '0;
         occ       <= '0;
      end else if (en) begin
         stage_data[0] <= in_data;
         for (int i = 1; i < DEPTH; i++) begin
            stage_data[i] <= stage_data[i-1];
         end
         stage_vld <= {stage_vld[DEPTH-2:0], in_valid};
         occ       <= occ + CNTW'(in_valid) - CNTW'(stage_vld[DEPTH-1]);
      end
   end

   // Out-of-range taps (non power-of-two DEPTH) read the last stage.
   always_comb begin
      tap = delay_sel;
      if ({1'b0, delay_sel} >= (SELW+1)'(DEPTH)) begin
         tap = SELW'(DEPTH - 1);
      end
   end

   assign out_data  = stage_data[tap];
   assign out_valid = stage_vld[tap];
   assign occupancy = occ;

`ifdef BUFFER_CHANGE_DETECT_EN
   logic [WIDTH-1:0] prev_out;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_out <= '0;
      end else if (out_valid) begin
         prev_out <= out_data;
      end
   end

   assign out_changed = out_valid & (out_data != prev_out);
`else
   assign out_changed = 1'b0;
`endif

endmodule

// File: tb/tb_param_shift_buffer.sv
// Self-checking bench for param_shift_buffer: scoreboard on the DEPTH=4 instance plus
// direct checks for stall, flush, async reset, tap clamp (DEPTH=3 instance) and change detect.
module tb_param_shift_buffer;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       flush;
   logic       in_valid;
   logic [7:0] in_data;
   logic [1:0] delay_sel;

   logic       out_valid;
   logic [7:0] out_data;
   logic [2:0] occupancy;
   logic       out_changed;

   logic       out_valid3;
   logic [7:0] out_data3;
   logic [1:0] occupancy3;
   logic       out_changed3;

   int checks = 0;
   int errors = 0;
   logic [7:0] sb_q [$];
   logic [2:0] exp_chg;

   param_shift_buffer #(.WIDTH(8), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .en(en), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .delay_sel(delay_sel),
      .out_valid(out_valid), .out_data(out_data),
      .occupancy(occupancy), .out_changed(out_changed)
   );

   param_shift_buffer #(.WIDTH(8), .DEPTH(3)) dut3 (
      .clk(clk), .reset(reset), .en(en), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .delay_sel(delay_sel),
      .out_valid(out_valid3), .out_data(out_data3),
      .occupancy(occupancy3), .out_changed(out_changed3)
   );

   always #5 clk = ~clk;

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drives one cycle of inputs at the falling edge; scoreboard pops whenever a shift lands a valid item on the tap.
   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic e, input logic f);
      @(negedge clk);
      en       = e;
      flush    = f;
      in_valid = v;
      in_data  = d;
      if (f) sb_q.delete();
      else if (e && v) sb_q.push_back(d);
      @(posedge clk);
      #1;
      if (e && !f && out_valid) begin
         if (sb_q.size() == 0) checkOutput("sb_unexpected_valid", 32'(out_valid), 32'd0);
         else checkOutput("sb_data", 32'(out_data), 32'(sb_q.pop_front()));
      end
   endtask

   initial begin
      reset     = 1'b1;
      en        = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      delay_sel = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_out_data", 32'(out_data), 32'd0);
      checkOutput("reset_occupancy", 32'(occupancy), 32'd0);
      checkOutput("reset_out_changed", 32'(out_changed), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      $display("[TB] stream with delay_sel=2");
      delay_sel = 2'd2;
      applyStimulus(1'b1, 8'h11, 1'b1, 1'b0);
      checkOutput("t1_valid_e1", 32'(out_valid), 32'd0);
      checkOutput("t1_occ_e1", 32'(occupancy), 32'd1);
      applyStimulus(1'b1, 8'h22, 1'b1, 1'b0);
      checkOutput("t1_valid_e2", 32'(out_valid), 32'd0);
      checkOutput("t1_occ_e2", 32'(occupancy), 32'd2);
      applyStimulus(1'b1, 8'h33, 1'b1, 1'b0);
      checkOutput("t1_valid_e3", 32'(out_valid), 32'd1);
      checkOutput("t1_data_e3", 32'(out_data), 32'h11);
      checkOutput("t1_occ_e3", 32'(occupancy), 32'd3);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("t1_drain", 32'(sb_q.size()), 32'd0);

      $display("[TB] stall with delay_sel=3");
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
      delay_sel = 2'd3;
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b1, 1'b0);
      checkOutput("t2_full_data", 32'(out_data), 32'hA0);
      checkOutput("t2_full_occ", 32'(occupancy), 32'd4);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 8'hBB, 1'b0, 1'b0);
         checkOutput("t2_stall_data", 32'(out_data), 32'hA0);
         checkOutput("t2_stall_valid", 32'(out_valid), 32'd1);
         checkOutput("t2_stall_occ", 32'(occupancy), 32'd4);
      end
      applyStimulus(1'b1, 8'hA4, 1'b1, 1'b0);
      checkOutput("t2_release_data", 32'(out_data), 32'hA1);
      checkOutput("t2_release_occ", 32'(occupancy), 32'd4);

      $display("[TB] flush while full");
      applyStimulus(1'b1, 8'h5A, 1'b1, 1'b1);
      checkOutput("t3_occ", 32'(occupancy), 32'd0);
      for (int s = 0; s < 4; s++) begin
         delay_sel = 2'(s);
         #1;
         checkOutput("t3_valid_tap", 32'(out_valid), 32'd0);
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
         checkOutput("t3_never_5a", 32'(out_valid), 32'd0);
      end
      checkOutput("t3_occ_floor", 32'(occupancy), 32'd0);

      $display("[TB] async reset mid-stream");
      delay_sel = 2'd0;
      applyStimulus(1'b1, 8'hC1, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'hC2, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'hC3, 1'b1, 1'b0);
      checkOutput("t4_occ_before", 32'(occupancy), 32'd3);
      #2 reset = 1'b1;
      #1;
      checkOutput("t4_rst_valid", 32'(out_valid), 32'd0);
      checkOutput("t4_rst_data", 32'(out_data), 32'd0);
      checkOutput("t4_rst_occ", 32'(occupancy), 32'd0);
      reset = 1'b0;
      sb_q.delete();
      applyStimulus(1'b1, 8'hD1, 1'b1, 1'b0);
      checkOutput("t4_resume_data", 32'(out_data), 32'hD1);
      applyStimulus(1'b1, 8'hD2, 1'b1, 1'b0);
      checkOutput("t4_resume_occ", 32'(occupancy), 32'd2);

      $display("[TB] tap sweep and clamp on DEPTH=3");
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
      applyStimulus(1'b1, 8'h03, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'h02, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'h01, 1'b1, 1'b0);
      en = 1'b0;
      for (int s = 0; s < 4; s++) begin
         delay_sel = 2'(s);
         #1;
         checkOutput("t5_tap_data", 32'(out_data3), (s == 3) ? 32'h03 : 32'(s + 1));
         checkOutput("t5_tap_valid", 32'(out_valid3), 32'd1);
      end
      checkOutput("t5_occ3", 32'(occupancy3), 32'd3);

      $display("[TB] change detect");
`ifdef BUFFER_CHANGE_DETECT_EN
      exp_chg = 3'b101;
`else
      exp_chg = 3'b000;
`endif
      @(negedge clk);
      reset = 1'b1;
      #2 reset = 1'b0;
      sb_q.delete();
      delay_sel = 2'd0;
      checkOutput("t6_chg_reset", 32'(out_changed), 32'd0);
      applyStimulus(1'b1, 8'h07, 1'b1, 1'b0);
      checkOutput("t6_chg_0", 32'(out_changed), 32'(exp_chg[0]));
      applyStimulus(1'b1, 8'h07, 1'b1, 1'b0);
      checkOutput("t6_chg_1", 32'(out_changed), 32'(exp_chg[1]));
      applyStimulus(1'b1, 8'h09, 1'b1, 1'b0);
      checkOutput("t6_chg_2", 32'(out_changed), 32'(exp_chg[2]));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("t6_drain", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
